seg_digit_scan: RTL and testbench

// - Upstream driver for the BCD-to-7-segment decoder in a multiplexed NDIG-digit display.
// - Holds an NDIG-digit packed BCD value and scans it one digit at a time at a prescaled rate.
// - Drives one 4-bit BCD nibble to the decoder's b3..b0 inputs and one active-low anode per digit.
// - Adds a glitch-free value update, leading-zero blanking and an anti-ghosting guard interval.

---
 rtl/seg_pkg.sv | 12 +
 rtl/seg_digit_scan_if.sv | 27 ++
 rtl/seg_prescaler.sv | 24 ++
 rtl/seg_digit_scan.sv | 95 +++++++++
 tb/tb_seg_digit_scan.sv | 134 +++++++++++++
 5 files changed

// File: rtl/seg_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment digit scanner.
package seg_pkg;

  localparam int SEG_NDIG_DEF = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

  // Active-low anode vector with only bit idx low; callers slice to NDIG bits.
  function automatic logic [7:0] onehot_n(input logic [2:0] idx);
    return ~(8'd1 << idx);
  endfunction

endpackage

// File: rtl/seg_digit_scan_if.sv
// Host/display signal bundle for seg_digit_scan; master is the host side.
interface seg_digit_scan_if
  import seg_pkg::*;
#(
  parameter int NDIG = SEG_NDIG_DEF
);

  logic              load;
  logic [4*NDIG-1:0] bcd_in;
  logic              blank_lz;
  logic              load_ack;
  logic [3:0]        digit;
  logic [NDIG-1:0]   an_n;
  logic              bad_digit;
  logic              frame_done;

  modport master (
    output load, bcd_in, blank_lz,
    input  load_ack, digit, an_n, bad_digit, frame_done
  );

  modport slave (
    input  load, bcd_in, blank_lz,
    output load_ack, digit, an_n, bad_digit, frame_done
  );

endinterface

// File: rtl/seg_prescaler.sv
// Digit-slot prescaler: pc counts 0..PRESCALE-1 and tick marks the last cycle of a slot.
module seg_prescaler #(
  parameter int PRESCALE = 50000,
  localparam int PCW = $clog2(PRESCALE)
) (
  input  logic           clk,
  input  logic           rst,
  output logic [PCW-1:0] pc,
  output logic           tick
);

  assign tick = (pc == PCW'(PRESCALE - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= '0;
    end else if (tick) begin
      pc <= '0;
    end else begin
      pc <= pc + 1'b1;
    end
  end

endmodule

// File: rtl/seg_digit_scan.sv
// Scans an NDIG-digit packed BCD value onto a multiplexed display, one digit per prescaled slot,
// with frame-aligned value updates, leading-zero blanking and an all-off guard at slot start.
module seg_digit_scan
  import seg_pkg::*;
#(
  parameter int NDIG     = SEG_NDIG_DEF,
  parameter int PRESCALE = 50000,
  parameter int GUARD    = 2
) (
  input logic              clk,
  input logic              rst,
  seg_digit_scan_if.slave  bus
);

  localparam int PCW = $clog2(PRESCALE);
  localparam int IW  = $clog2(NDIG);
  localparam int DW  = 4 * NDIG;

  logic [PCW-1:0] pc;
  logic           tick;
  logic [IW-1:0]  idx;
  logic           wrap;
  logic [DW-1:0]  shadow;
  logic [DW-1:0]  pending;
  logic           pend_flag;

  logic [3:0]     cur_nib;
  logic           cur_bad;
  logic           guard_on;
  logic           upper_nz;
  logic           blank;
  logic [7:0]     an_full;
  logic [NDIG-1:0] anode_n;

  seg_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .pc   (pc),
    .tick (tick)
  );

  assign wrap     = tick && (idx == IW'(NDIG - 1));
  assign cur_nib  = shadow[{idx, 2'b00} +: 4];
  assign cur_bad  = (cur_nib > BCD_MAX);
  assign guard_on = (int'(pc) < GUARD);
  assign an_full  = onehot_n(3'(idx));
  assign anode_n  = an_full[NDIG-1:0];

  // A slot is a leading zero when it and every more-significant digit are zero.
  always_comb begin
    upper_nz = 1'b0;
    for (int k = 0; k < NDIG; k++) begin
      if ((k >= int'(idx)) && (shadow[4*k +: 4] != 4'd0)) begin
        upper_nz = 1'b1;
      end
    end
    blank = bus.blank_lz && (idx != '0) && !upper_nz;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx            <= '0;
      shadow         <= '0;
      pending        <= '0;
      pend_flag      <= 1'b0;
      bus.load_ack   <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.digit      <= 4'd0;
      bus.bad_digit  <= 1'b0;
      bus.an_n       <= '1;
    end else begin
      if (tick) begin
        idx <= wrap ? '0 : idx + 1'b1;
      end
      // Shadow only changes at a frame boundary so a frame never mixes old and new digits.
      if (wrap) begin
        pend_flag <= 1'b0;
        if (bus.load) begin
          shadow <= bus.bcd_in;
        end else if (pend_flag) begin
          shadow <= pending;
        end
      end else if (bus.load) begin
        pending   <= bus.bcd_in;
        pend_flag <= 1'b1;
      end
      bus.load_ack   <= wrap && (bus.load || pend_flag);
      bus.frame_done <= wrap;
      bus.digit      <= cur_nib;
      bus.bad_digit  <= cur_bad;
      bus.an_n       <= (guard_on || blank || cur_bad) ? '1 : anode_n;
    end
  end

endmodule

// File: tb/tb_seg_digit_scan.sv
// Directed bench for seg_digit_scan: frame-by-frame expected anode/digit patterns.
module tb_seg_digit_scan;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   tests_run    = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  seg_digit_scan_if #(.NDIG(4)) bus_a ();
  seg_digit_scan_if #(.NDIG(4)) bus_b ();

  seg_digit_scan #(.NDIG(4), .PRESCALE(4), .GUARD(1)) dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (bus_a)
  );

  seg_digit_scan #(.NDIG(4), .PRESCALE(5), .GUARD(0)) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (bus_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One 16-cycle frame of dut_a. exp_an holds the lit anode pattern per slot (nibble s = slot s).
  task automatic run_frame(input int fr, input logic [15:0] exp_dig, input logic [15:0] exp_an,
                           input logic [3:0] exp_bad, input int ld1_at, input logic [15:0] ld1_val,
                           input int ld2_at, input logic [15:0] ld2_val, input bit exp_ack);
    for (int j = 0; j < 16; j++) begin
      int s;
      logic [3:0] edig;
      logic [3:0] ean;
      s = j / 4;
      if (j == ld1_at) begin
        bus_a.load   = 1'b1;
        bus_a.bcd_in = ld1_val;
      end else if (j == ld2_at) begin
        bus_a.load   = 1'b1;
        bus_a.bcd_in = ld2_val;
      end
      step();
      bus_a.load = 1'b0;
      edig = exp_dig[4*s +: 4];
      ean  = ((j % 4) < 1) ? 4'hf : exp_an[4*s +: 4];
      chk($sformatf("f%0d_c%0d_an", fr, j), 32'(bus_a.an_n), 32'(ean));
      chk($sformatf("f%0d_c%0d_digit", fr, j), 32'(bus_a.digit), 32'(edig));
      chk($sformatf("f%0d_c%0d_bad", fr, j), 32'(bus_a.bad_digit), 32'(exp_bad[s]));
      chk($sformatf("f%0d_c%0d_ack", fr, j), 32'(bus_a.load_ack), 32'(exp_ack && (j == 15)));
      chk($sformatf("f%0d_c%0d_fdone", fr, j), 32'(bus_a.frame_done), 32'(j == 15));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_a          = 1'b1;
    rst_b          = 1'b1;
    bus_a.load     = 1'b0;
    bus_a.bcd_in   = 16'h0;
    bus_a.blank_lz = 1'b1;
    bus_b.load     = 1'b0;
    bus_b.bcd_in   = 16'h0;
    bus_b.blank_lz = 1'b0;

    repeat (3) step();
    chk("rst_an", 32'(bus_a.an_n), 32'hf);
    chk("rst_digit", 32'(bus_a.digit), 32'h0);
    chk("rst_ack", 32'(bus_a.load_ack), 32'h0);
    chk("rst_fdone", 32'(bus_a.frame_done), 32'h0);
    chk("rst_bad", 32'(bus_a.bad_digit), 32'h0);
    rst_a = 1'b0;

    // Blank display shows only digit 0; a mid-frame load waits for the boundary.
    run_frame(0, 16'h0000, 16'hfffe, 4'b0000, 6, 16'h1234, -1, 16'h0, 1'b1);
    run_frame(1, 16'h1234, 16'h7bde, 4'b0000, 3, 16'h1111, 9, 16'h0042, 1'b1);
    run_frame(2, 16'h0042, 16'hffde, 4'b0000, -1, 16'h0, -1, 16'h0, 1'b0);
    bus_a.blank_lz = 1'b0;
    run_frame(3, 16'h0042, 16'h7bde, 4'b0000, 15, 16'h0000, -1, 16'h0, 1'b1);
    bus_a.blank_lz = 1'b1;
    run_frame(4, 16'h0000, 16'hfffe, 4'b0000, 4, 16'h0A05, -1, 16'h0, 1'b1);
    run_frame(5, 16'h0A05, 16'hffde, 4'b0100, -1, 16'h0, -1, 16'h0, 1'b0);

    // Reset with a load pending: the pending value must be dropped.
    bus_a.load   = 1'b1;
    bus_a.bcd_in = 16'h9999;
    step();
    bus_a.load = 1'b0;
    repeat (4) step();
    rst_a = 1'b1;
    repeat (2) step();
    chk("mid_rst_an", 32'(bus_a.an_n), 32'hf);
    chk("mid_rst_digit", 32'(bus_a.digit), 32'h0);
    chk("mid_rst_ack", 32'(bus_a.load_ack), 32'h0);
    chk("mid_rst_fdone", 32'(bus_a.frame_done), 32'h0);
    chk("mid_rst_bad", 32'(bus_a.bad_digit), 32'h0);
    rst_a = 1'b0;
    run_frame(7, 16'h0000, 16'hfffe, 4'b0000, -1, 16'h0, -1, 16'h0, 1'b0);

    // No guard: anodes never all off, one frame every 20 cycles.
    rst_b = 1'b0;
    for (int c = 0; c < 60; c++) begin
      int s;
      logic [3:0] ean;
      step();
      s   = (c / 5) % 4;
      ean = 4'hf ^ (4'b0001 << s);
      chk($sformatf("b_c%0d_an", c), 32'(bus_b.an_n), 32'(ean));
      chk($sformatf("b_c%0d_fdone", c), 32'(bus_b.frame_done), 32'((c % 20) == 19));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
